// File: rtl/avalon_bram_burst_pkg.sv
// Shared types and width helpers for the Avalon BRAM burst agent.
package avalon_bram_pkg;

    // Agent command state: idle, streaming a read burst, or collecting write-burst beats
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_e;

    // Number of byte lanes on a data bus of data_w bits
    function automatic int calc_be_w(input int data_w);
        return data_w / 8;
    endfunction

    // Number of byte-address bits below the word index
    function automatic int calc_byte_lsb(input int data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 0;
    endfunction

endpackage

// File: rtl/avalon_bram_burst_sdp.sv
// Simple dual-port RAM: one byte-enabled write port and one registered read port.
// Each byte lane is its own narrow memory so that the per-byte enables map
// directly onto block-RAM write enables.
module bram_be_sdp #(
    parameter  int DATA_W    = 32,
    parameter  int RAM_ADD_W = 11,
    localparam int BE_W      = DATA_W / 8,
    localparam int DEPTH     = 2 ** RAM_ADD_W
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [RAM_ADD_W-1:0] wr_addr_i,
    input  logic [BE_W-1:0]      wr_be_i,
    input  logic [DATA_W-1:0]    wr_data_i,
    input  logic                 rd_en_i,
    input  logic [RAM_ADD_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0]    rd_data_o
);

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rd_q;

        // Lane write: only when the port is enabled and this byte is selected
        always_ff @(posedge clk) begin
            if (wr_en_i && wr_be_i[gi]) begin
                mem_q[wr_addr_i] <= wr_data_i[8*gi +: 8];
            end
        end

        // Registered read; output holds its value when no read is issued
        always_ff @(posedge clk) begin
            if (rd_en_i) begin
                rd_q <= mem_q[rd_addr_i];
            end
        end

        assign rd_data_o[8*gi +: 8] = rd_q;
    end

endmodule

// File: rtl/avalon_bram_burst.sv
// Avalon-MM memory slave around a byte-enabled block RAM. Supports single and
// burst transfers in both directions with one-cycle read latency; read bursts
// stream back-to-back and word indices wrap modulo the RAM depth.
module avalon_bram_burst
    import avalon_bram_pkg::*;
#(
    parameter  int DATA_W       = 32,
    parameter  int RAM_ADD_W    = 11,
    parameter  int BURSTCOUNT_W = 4,
    localparam int BE_W         = calc_be_w(DATA_W),
    localparam int BYTE_LSB     = calc_byte_lsb(DATA_W),
    localparam int ADDR_W       = RAM_ADD_W + BYTE_LSB
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       address,
    input  logic [BE_W-1:0]         byteenable,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_W-1:0]       writedata,
    input  logic [BURSTCOUNT_W-1:0] burstcount,
    output logic [DATA_W-1:0]       readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest
);

    state_e                  state_q, state_d;
    logic [RAM_ADD_W-1:0]    idx_q, idx_d;
    logic [BURSTCOUNT_W-1:0] remain_q, remain_d;
    logic                    rvalid_q;
    logic                    wait_q, wait_d;

    logic                    ram_we;
    logic [RAM_ADD_W-1:0]    ram_waddr;
    logic                    ram_re;
    logic [RAM_ADD_W-1:0]    ram_raddr;
    logic [DATA_W-1:0]       ram_rdata;

    logic [RAM_ADD_W-1:0]    cmd_word;
    logic                    cmd_multi;

    assign cmd_word  = address[ADDR_W-1:BYTE_LSB];
    // burstcount 0 and 1 both mean a single beat
    assign cmd_multi = (burstcount > BURSTCOUNT_W'(1));

    // Byte-offset bits are deliberately ignored; fold them so they are consumed
    if (BYTE_LSB > 0) begin : g_lsb
        logic unused_byte_bits;
        assign unused_byte_bits = ^address[BYTE_LSB-1:0];
    end

    // Next-state, burst bookkeeping and RAM port control
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        remain_d  = remain_q;
        ram_we    = 1'b0;
        ram_waddr = cmd_word;
        ram_re    = 1'b0;
        ram_raddr = cmd_word;

        case (state_q)
            IDLE: begin
                // wait_q is only high here in the first cycle after reset release
                if (!wait_q) begin
                    if (write) begin
                        // write has priority; a simultaneous read is dropped
                        ram_we    = 1'b1;
                        ram_waddr = cmd_word;
                        if (cmd_multi) begin
                            idx_d    = cmd_word + RAM_ADD_W'(1);
                            remain_d = burstcount - BURSTCOUNT_W'(1);
                            state_d  = WR_BURST;
                        end
                    end else if (read) begin
                        ram_re    = 1'b1;
                        ram_raddr = cmd_word;
                        if (cmd_multi) begin
                            idx_d    = cmd_word + RAM_ADD_W'(1);
                            remain_d = burstcount - BURSTCOUNT_W'(1);
                            state_d  = RD_BURST;
                        end
                    end
                end
            end

            RD_BURST: begin
                // one beat per cycle, bus inputs ignored
                ram_re    = 1'b1;
                ram_raddr = idx_q;
                idx_d     = idx_q + RAM_ADD_W'(1);
                remain_d  = remain_q - BURSTCOUNT_W'(1);
                if (remain_q == BURSTCOUNT_W'(1)) begin
                    state_d = IDLE;
                end
            end

            WR_BURST: begin
                // write=0 stalls; address/burstcount/read are don't-care here
                if (write) begin
                    ram_we    = 1'b1;
                    ram_waddr = idx_q;
                    idx_d     = idx_q + RAM_ADD_W'(1);
                    remain_d  = remain_q - BURSTCOUNT_W'(1);
                    if (remain_q == BURSTCOUNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // waitrequest is registered so it is glitch-free and high only while streaming reads
    assign wait_d = (state_d == RD_BURST);

    // State, burst counters and response flags; reset leaves RAM contents untouched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            remain_q <= '0;
            rvalid_q <= 1'b0;
            wait_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            remain_q <= remain_d;
            rvalid_q <= ram_re;
            wait_q   <= wait_d;
        end
    end

    bram_be_sdp #(
        .DATA_W    (DATA_W),
        .RAM_ADD_W (RAM_ADD_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (ram_waddr),
        .wr_be_i   (byteenable),
        .wr_data_i (writedata),
        .rd_en_i   (ram_re),
        .rd_addr_i (ram_raddr),
        .rd_data_o (ram_rdata)
    );

    // Gate the RAM output so readdata is zero whenever no beat is presented
    assign readdata      = rvalid_q ? ram_rdata : '0;
    assign readdatavalid = rvalid_q;
    assign waitrequest   = wait_q;

endmodule

// File: tb/tb_avalon_bram_burst.sv
// Randomised bench for avalon_bram_burst with a transaction-level memory model.
module tb_avalon_bram_burst;

    localparam int DATA_W       = 32;
    localparam int RAM_ADD_W    = 11;
    localparam int BURSTCOUNT_W = 4;
    localparam int BE_W         = 4;
    localparam int ADDR_W       = 13;
    localparam int DEPTH        = 2048;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [ADDR_W-1:0]       address;
    logic [BE_W-1:0]         byteenable;
    logic                    read;
    logic                    write;
    logic [DATA_W-1:0]       writedata;
    logic [BURSTCOUNT_W-1:0] burstcount;
    logic [DATA_W-1:0]       readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    always #5 clk = ~clk;

    avalon_bram_burst #(
        .DATA_W       (DATA_W),
        .RAM_ADD_W    (RAM_ADD_W),
        .BURSTCOUNT_W (BURSTCOUNT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .byteenable    (byteenable),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .burstcount    (burstcount),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest)
    );

    // Reference model: memory image, expected read beats keyed by cycle, busy window
    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] exp_rd [int];
    int  wait_end    = -1;
    int  cyc_cnt     = 0;
    bit  edge_seen   = 1'b0;
    bit  chk_en      = 1'b0;
    int  n_vec       = 0;
    int  n_err       = 0;
    int  wait_hi_cnt = 0;
    int  valid_cnt   = 0;
    logic [DATA_W-1:0] wdat [16];
    logic [BE_W-1:0]   wbe  [16];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_seen <= 1'b0;
        else          edge_seen <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: cycle %0d got %h expected %h", name, cyc_cnt, act, exp);
        end
    endtask

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            if (!reset_n) begin
                check("rst_valid", 32'(readdatavalid), 32'd0);
                check("rst_wait",  32'(waitrequest),   32'd1);
                check("rst_data",  readdata,           32'd0);
            end else begin
                bit ev;
                ev = exp_rd.exists(cyc_cnt);
                check("rdvalid", 32'(readdatavalid), 32'(ev));
                if (ev) begin
                    check("rddata", readdata, exp_rd[cyc_cnt]);
                    exp_rd.delete(cyc_cnt);
                end
                check("waitreq", 32'(waitrequest), 32'(!edge_seen || cyc_cnt <= wait_end));
                if (waitrequest)   wait_hi_cnt++;
                if (readdatavalid) valid_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_junk();
        read       = 1'($urandom);
        write      = 1'($urandom);
        address    = ADDR_W'($urandom);
        burstcount = BURSTCOUNT_W'($urandom);
        byteenable = BE_W'($urandom);
        writedata  = $urandom;
    endtask

    task automatic drive_idle();
        drive_junk();
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic model_write(input int w, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) model[w % DEPTH][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic set_cmd_addr(input int word);
        address = ADDR_W'(((word % DEPTH) << 2) | $urandom_range(0, 3));
    endtask

    // Read of nraw beats; returns so that the next command lands on the first free edge
    task automatic do_read(input int word, input int nraw);
        int n;
        int t;
        n = (nraw == 0) ? 1 : nraw;
        drive_junk();
        read  = 1'b1;
        write = 1'b0;
        set_cmd_addr(word);
        burstcount = BURSTCOUNT_W'(nraw);
        step();
        t = cyc_cnt;
        for (int i = 0; i < n; i++) exp_rd[t + i] = model[(word + i) % DEPTH];
        if (n > 1) wait_end = t + n - 2;
        $display("RD  word=%03h beats=%0d", word % DEPTH, n);
        for (int i = 1; i < n; i++) begin
            drive_junk();
            step();
        end
        drive_idle();
    endtask

    // Write burst using wdat/wbe; stall_len idle beats before beat index stall_at
    task automatic do_write(input int word, input int nraw, input int stall_at,
                            input int stall_len, input bit rnd_stall);
        int n;
        int s;
        n = (nraw == 0) ? 1 : nraw;
        drive_junk();
        write      = 1'b1;
        set_cmd_addr(word);
        burstcount = BURSTCOUNT_W'(nraw);
        writedata  = wdat[0];
        byteenable = wbe[0];
        step();
        model_write(word, wdat[0], wbe[0]);
        for (int i = 1; i < n; i++) begin
            s = (i == stall_at) ? stall_len : ((rnd_stall && $urandom_range(0, 3) == 0) ? 1 : 0);
            for (int k = 0; k < s; k++) begin
                drive_junk();
                write = 1'b0;
                step();
            end
            drive_junk();
            write      = 1'b1;
            writedata  = wdat[i];
            byteenable = wbe[i];
            step();
            model_write(word + i, wdat[i], wbe[i]);
        end
        $display("WR  word=%03h beats=%0d", word % DEPTH, n);
        drive_idle();
    endtask

    task automatic write1(input int word, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        wdat[0] = d;
        wbe[0]  = be;
        do_write(word, 1, 0, 0, 1'b0);
    endtask

    // Single read with a hand-computed expected value
    task automatic read_lit(input string name, input int word, input logic [DATA_W-1:0] exp);
        do_read(word, 1);
        @(negedge clk);
        #1;
        check(name, readdata, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int word;
        drive_idle();
        reset_n = 1'b0;
        chk_en  = 1'b1;
        repeat (2) step();
        check("reset_wait",  32'(waitrequest),   32'd1);
        check("reset_valid", 32'(readdatavalid), 32'd0);
        check("reset_data",  readdata,           32'd0);
        reset_n = 1'b1;
        step();

        // Fill the whole RAM with known random data through 15-beat bursts
        for (int w = 0; w < DEPTH; w += 15) begin
            for (int i = 0; i < 15; i++) begin
                wdat[i] = $urandom;
                wbe[i]  = 4'hF;
            end
            do_write(w, 15, 0, 0, 1'b1);
        end

        // Full-word write then read-back
        write1(32'h10 >> 2, 32'hDEADBEEF, 4'hF);
        read_lit("single_rw", 32'h10 >> 2, 32'hDEADBEEF);

        // Partial byte enables merge with old contents
        write1(32'h20 >> 2, 32'hFFFFFFFF, 4'hF);
        write1(32'h20 >> 2, 32'h11223344, 4'b0101);
        read_lit("byteenable", 32'h20 >> 2, 32'hFF22FF44);

        // Four-beat write burst with a two-cycle stall before the third beat
        for (int i = 0; i < 4; i++) begin
            wdat[i] = 32'(i + 1);
            wbe[i]  = 4'hF;
        end
        do_write(32'h40 >> 2, 4, 2, 2, 1'b0);
        for (int i = 0; i < 4; i++) read_lit("wr_burst_stall", 16 + i, 32'(i + 1));

        // Write burst crossing the top of memory wraps to word 0
        wdat[0] = 32'hA5A5_0001; wdat[1] = 32'hA5A5_0002; wdat[2] = 32'hA5A5_0003;
        wbe[0] = 4'hF; wbe[1] = 4'hF; wbe[2] = 4'hF;
        do_write(12'h7FF, 3, 0, 0, 1'b0);
        read_lit("wr_wrap_top",  12'h7FF, 32'hA5A5_0001);
        read_lit("wr_wrap_zero", 0,       32'hA5A5_0002);

        // Eight-beat read wrapping past the top; busy for exactly seven cycles
        wait_hi_cnt = 0;
        do_read(12'h7FE, 8);
        step();
        step();
        check("wrap_wait_cycles", 32'(wait_hi_cnt), 32'd7);

        // Two back-to-back three-beat reads stream as six contiguous beats
        valid_cnt = 0;
        do_read(100, 3);
        do_read(200, 3);
        step();
        step();
        check("b2b_valid_cycles", 32'(valid_cnt), 32'd6);

        // Reset after the second beat of a six-beat read
        word = 300;
        drive_junk();
        read       = 1'b1;
        write      = 1'b0;
        set_cmd_addr(word);
        burstcount = 4'd6;
        step();
        t = cyc_cnt;
        for (int i = 0; i < 6; i++) exp_rd[t + i] = model[(word + i) % DEPTH];
        wait_end = t + 4;
        drive_junk();
        step();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        exp_rd.delete();
        wait_end = -1;
        #1;
        check("rst_async_valid", 32'(readdatavalid), 32'd0);
        check("rst_async_wait",  32'(waitrequest),   32'd1);
        $display("RST mid-burst word=%03h", word);
        drive_idle();
        repeat (3) step();
        reset_n = 1'b1;
        step();
        read_lit("after_rst_read",  32'h10 >> 2, 32'hDEADBEEF);
        read_lit("after_rst_burst", 12'h7FF,     32'hA5A5_0001);

        // Randomised mix of reads, writes, stalls and idle gaps
        for (int it = 0; it < 120; it++) begin
            int op;
            op   = $urandom_range(0, 2);
            word = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 8, DEPTH - 1) : $urandom_range(0, DEPTH - 1);
            if (op == 0) begin
                for (int i = 0; i < 16; i++) begin
                    wdat[i] = $urandom;
                    wbe[i]  = BE_W'($urandom);
                end
                do_write(word, $urandom_range(0, 15), 0, 0, 1'b1);
            end else begin
                do_read(word, $urandom_range(0, 15));
            end
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (4) step();
        check("pending_beats", 32'(exp_rd.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/avalon_bram_burst.md
# avalon_bram_burst

Parametrised Avalon-MM agent wrapping an on-chip block RAM with byte enables, single and burst transfers in both directions, and a pipelined one-cycle read latency. It is the next generation of the team's Avalon BRAM agent. It generalises data width and depth, adds back-to-back read bursts without idle cycles and defined wrap-around. It sits behind the interconnect as a memory slave for the processor or DMA hosts.

## Interface

Parameters:
- DATA_W, 32: data bus width in bits; multiple of 8, ≥ 8; BE_W = DATA_W/8.
- RAM_ADD_W, 11: word-address width; depth = 2**RAM_ADD_W words.
- BURSTCOUNT_W, 4: burstcount width; bursts of 1..2**BURSTCOUNT_W-1 beats are honoured.
- Derived: BYTE_LSB = clog2(BE_W); ADDR_W = RAM_ADD_W + BYTE_LSB.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- address, input, ADDR_W: byte address; word index = address[ADDR_W-1:BYTE_LSB]; low bits ignored.
- byteenable, input, BE_W: per-byte write enable; ignored on reads.
- read, input, 1: read request.
- write, input, 1: write request or write-burst beat.
- writedata, input, DATA_W: write data.
- burstcount, input, BURSTCOUNT_W: beats in the transfer; 0 is treated as 1.
- readdata, output, DATA_W: read data, qualified by readdatavalid.
- readdatavalid, output, 1: one pulse per returned beat.
- waitrequest, output, 1: high means the command is not accepted this cycle.

## Operation

- States: IDLE, RD_BURST, WR_BURST. There is no separate reset state.
- IDLE, waitrequest=0:
  - A command is accepted in any cycle where read or write is high.
  - write wins over read when both are high; the read is dropped and never answered.
  - Read, burstcount ≤ 1: memory[word] is read; stay in IDLE.
  - Read, N>1: beat 0 is read; latch next index = word+1 and remaining = N-1; go to RD_BURST.
  - Write, any burstcount: beat 0 is written with byteenable.
  - Write, N>1: latch next index and remaining = N-1; go to WR_BURST.
- RD_BURST, waitrequest=1:
  - One word is read per cycle at the latched index; index +1 and remaining −1.
  - When remaining reaches 1 and that beat is issued, go to IDLE.
  - read/write inputs are ignored.
- WR_BURST, waitrequest=0:
  - Each cycle with write=1 writes writedata/byteenable at the latched index; index +1 and remaining −1.
  - address and burstcount are ignored on these beats.
  - write=0 stalls the burst with no state change.
  - The last beat returns the block to IDLE.
  - read=1 in this state is ignored.
- Word index arithmetic is modulo 2**RAM_ADD_W: a burst crossing the top wraps to word 0.
- Memory contents are not reset and are retained across reset.
- Byte lane b maps to writedata[8b+7:8b].

## Timing

- Reset values:
  - readdatavalid=0, readdata=0.
  - waitrequest=1 while reset_n=0; waitrequest=0 from the first clk edge after release.
  - State = IDLE.
- Read latency is 1 cycle: a read accepted or issued at edge T gives readdata and readdatavalid=1 during cycle T+1.
- N-beat read accepted at T:
  - Beats appear at T+1 … T+N, one per cycle, with no gaps.
  - waitrequest is high during T+1 … T+N-1.
  - A new command may be accepted at T+N, so back-to-back bursts stream without a bubble.
- Write takes effect at the accepting edge. A read of the same word accepted the next cycle returns the new data.
- Reset asserted mid-burst:
  - State goes to IDLE immediately and readdatavalid drops asynchronously.
  - Outstanding beats are discarded and never returned.
  - Writes already performed remain.

## Structure

- Package avalon_bram_pkg holds the state enum (IDLE, RD_BURST, WR_BURST) and the BE_W/BYTE_LSB derivation functions.
- Sub-module bram_be_sdp: simple dual-port RAM with one write port (per-byte enables) and one registered read port, parametrised by DATA_W and RAM_ADD_W. It must infer block RAM.
- The top module contains the FSM, burst counter, address incrementer and readdatavalid register.

## Test plan

- After reset, write 0xDEADBEEF to byte address 0x10 with byteenable=4'hF; single read at 0x10 → readdatavalid one cycle later with 0xDEADBEEF.
- Write 0x11223344 to 0x20 with byteenable=4'b0101 over prior 0xFFFFFFFF → read returns 0xFF22FF44.
- Write burst of 4 at 0x40 with data 1..4, write deasserted for 2 cycles after beat 2 → reads of words 0x10..0x13 return 1,2,3,4.
- Read burst of 8 at word 0x7FE (RAM_ADD_W=11) → 8 consecutive valid beats from words 0x7FE, 0x7FF, 0x000 … 0x005; waitrequest high for exactly 7 cycles.
- Two read bursts of 3 issued back-to-back → 6 contiguous readdatavalid cycles, no bubble.
- Assert reset_n=0 after beat 2 of a 6-beat read → readdatavalid=0 at once; no further beats; first read after release returns correct stored data.
